// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared constants for the I2C register-bank arbiter. Holds
//               the FSM state encoding, the write/read operation codes and
//               the timeout counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANT   = 2'd1;
    localparam logic [1:0] c_ACCESS  = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    localparam logic c_WRITE_OP = 1'b1;
    localparam logic c_READ_OP  = 1'b0;

    localparam int c_TMO_CNT_W = 8;

endpackage : i2c_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Scans the request vector
//               starting at the pointer position, wrapping past the top,
//               and returns the first requester found.
// Ports       : i_req   - request vector
//               i_ptr   - index with the highest priority this round
//               o_grant - one-hot winner
//               o_idx   - binary index of the winner
//               o_valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NOF_REQUESTERS = 2,
    parameter int IDX_W          = 1
) (
    input  logic [NOF_REQUESTERS-1:0] i_req,
    input  logic [IDX_W-1:0]          i_ptr,
    output logic [NOF_REQUESTERS-1:0] o_grant,
    output logic [IDX_W-1:0]          o_idx,
    output logic                      o_valid
);

    int w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = 0;
        for (int i = 0; i < NOF_REQUESTERS; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NOF_REQUESTERS) begin
                w_k = w_k - NOF_REQUESTERS;
            end
            if (!o_valid && i_req[w_k]) begin
                o_valid      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k[IDX_W-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/i2c_regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_regbank_arbiter
// Description : Shared 8-bit configuration register bank with a round-robin
//               req/gnt/ack arbiter. Requester 0 is the I2C slave. The whole
//               bank is mirrored on data_o (word 0 in the LSBs).
// Ports       : clk_i, reset_i (async, active-low)
//               req_i/we_i/addr_i/wdata_i - per-requester access request
//               gnt_o (one-hot), ack_o (1-cycle), rdata_o, err_o, busy_o
//               data_o - bank mirror
// Options     : I2C_ARB_LOCK_EN - adds lock_i; a locked winner keeps the
//               grant across repeated accesses without rearbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_regbank_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NOF_REQUESTERS   = 2,
    parameter int NOF_DATA_WORDS   = 2,
    parameter int NOF_ADDRESS_BITS = 1,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [NOF_REQUESTERS-1:0]              req_i,
    input  logic [NOF_REQUESTERS-1:0]              we_i,
`ifdef I2C_ARB_LOCK_EN
    input  logic [NOF_REQUESTERS-1:0]              lock_i,
`endif
    input  logic [NOF_REQUESTERS*NOF_ADDRESS_BITS-1:0] addr_i,
    input  logic [NOF_REQUESTERS*8-1:0]            wdata_i,
    output logic [NOF_REQUESTERS-1:0]              gnt_o,
    output logic [NOF_REQUESTERS-1:0]              ack_o,
    output logic [7:0]                             rdata_o,
    output logic                                   err_o,
    output logic                                   busy_o,
    output logic [NOF_DATA_WORDS*8-1:0]            data_o
);

    localparam int c_IDX_W = (NOF_REQUESTERS > 1) ? $clog2(NOF_REQUESTERS) : 1;
    localparam logic [c_TMO_CNT_W-1:0] c_TMO_LAST = c_TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]                    r_state;
    logic [c_IDX_W-1:0]            r_ptr;
    logic [c_IDX_W-1:0]            r_win;
    logic                          r_we;
    logic [NOF_ADDRESS_BITS-1:0]   r_addr;
    logic [7:0]                    r_wdata;
    logic [c_TMO_CNT_W-1:0]        r_cnt;
    logic [NOF_DATA_WORDS*8-1:0]   r_bank;
    logic [NOF_REQUESTERS-1:0]     r_gnt;
    logic [NOF_REQUESTERS-1:0]     r_ack;
    logic [7:0]                    r_rdata;
    logic                          r_err;

    logic [NOF_REQUESTERS-1:0]     w_onehot;
    logic [c_IDX_W-1:0]            w_idx;
    logic                          w_any;
    logic                          w_in_range;
    logic                          w_is_read;

    rr_arbiter #(
        .NOF_REQUESTERS (NOF_REQUESTERS),
        .IDX_W          (c_IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_grant (w_onehot),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_in_range = (int'(r_addr) < NOF_DATA_WORDS);
    assign w_is_read  = (r_we == c_READ_OP);

`ifdef I2C_ARB_LOCK_EN
    logic r_locked;
    logic r_seen_low;
    logic w_new_ops;

    // A held request counts as a fresh access once its operands change.
    assign w_new_ops = (we_i[r_win] != r_we) ||
                       (addr_i[r_win*NOF_ADDRESS_BITS +: NOF_ADDRESS_BITS] != r_addr) ||
                       (wdata_i[r_win*8 +: 8] != r_wdata);
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_we    <= c_READ_OP;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_bank  <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
`ifdef I2C_ARB_LOCK_EN
            r_locked   <= 1'b0;
            r_seen_low <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_onehot;
                        r_win   <= w_idx;
                        r_we    <= we_i[w_idx];
                        r_addr  <= addr_i[w_idx*NOF_ADDRESS_BITS +: NOF_ADDRESS_BITS];
                        r_wdata <= wdata_i[w_idx*8 +: 8];
                        r_state <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    r_state <= c_ACCESS;
                end
                c_ACCESS: begin
                    if (w_in_range) begin
                        if (r_we == c_WRITE_OP) begin
                            r_bank[int'(r_addr)*8 +: 8] <= r_wdata;
                        end else begin
                            r_rdata <= r_bank[int'(r_addr)*8 +: 8];
                        end
                    end else begin
                        // Out-of-range: drop writes, reads return zero.
                        if (w_is_read) begin
                            r_rdata <= 8'h00;
                        end
                        r_err <= 1'b1;
                    end
                    r_ack[r_win] <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= c_RELEASE;
`ifdef I2C_ARB_LOCK_EN
                    r_locked   <= lock_i[r_win];
                    r_seen_low <= 1'b0;
                    if (!lock_i[r_win]) begin
`else
                    begin
`endif
                        if (int'(r_win) == NOF_REQUESTERS - 1) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_win + 1'b1;
                        end
                    end
                end
                c_RELEASE: begin
`ifdef I2C_ARB_LOCK_EN
                    if (r_locked) begin
                        if (!req_i[r_win]) begin
                            r_seen_low <= 1'b1;
                        end
                        if (req_i[r_win] && (r_seen_low || w_new_ops)) begin
                            r_we       <= we_i[r_win];
                            r_addr     <= addr_i[r_win*NOF_ADDRESS_BITS +: NOF_ADDRESS_BITS];
                            r_wdata    <= wdata_i[r_win*8 +: 8];
                            r_seen_low <= 1'b0;
                            r_state    <= c_GRANT;
                        end else if (r_cnt == c_TMO_LAST) begin
                            // Forced release also ends the lock, so the
                            // pointer moves past the stalled owner.
                            r_gnt      <= '0;
                            r_err      <= 1'b1;
                            r_locked   <= 1'b0;
                            r_seen_low <= 1'b0;
                            r_state    <= c_IDLE;
                            if (int'(r_win) == NOF_REQUESTERS - 1) begin
                                r_ptr <= '0;
                            end else begin
                                r_ptr <= r_win + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else
`endif
                    if (!req_i[r_win]) begin
                        r_gnt   <= '0;
                        r_state <= c_IDLE;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_gnt   <= '0;
                        r_err   <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign gnt_o   = r_gnt;
    assign ack_o   = r_ack;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;
    assign busy_o  = (r_state != c_IDLE);
    assign data_o  = r_bank;

endmodule : i2c_regbank_arbiter
`default_nettype wire

// File: tb/tb_i2c_regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_regbank_arbiter
// Description : Scoreboard bench for i2c_regbank_arbiter with 2 requesters,
//               3 data words and 2 address bits, so out-of-range addresses
//               are reachable. Expected ack responses are queued by the
//               stimulus and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_regbank_arbiter;

    localparam int N  = 2;
    localparam int W  = 3;
    localparam int AB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [1:0] addr0 = '0, addr1 = '0;
    logic [7:0] wd0 = '0, wd1 = '0;

    logic [N-1:0]    req_i, we_i;
    logic [N*AB-1:0] addr_i;
    logic [N*8-1:0]  wdata_i;
    logic [N-1:0]    gnt_o, ack_o;
    logic [7:0]      rdata_o;
    logic            err_o, busy_o;
    logic [W*8-1:0]  data_o;

    assign req_i   = {req1, req0};
    assign we_i    = {we1, we0};
    assign addr_i  = {addr1, addr0};
    assign wdata_i = {wd1, wd0};

    i2c_regbank_arbiter #(
        .NOF_REQUESTERS   (N),
        .NOF_DATA_WORDS   (W),
        .NOF_ADDRESS_BITS (AB),
        .TIMEOUT_CYCLES   (255)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .gnt_o   (gnt_o),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .busy_o  (busy_o),
        .data_o  (data_o)
    );

    typedef struct {
        logic [1:0]  ack;
        logic        chk_rd;
        logic [7:0]  rdata;
        logic        err;
        logic [23:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic chk, input logic [7:0] rd,
                        input logic e, input logic [23:0] d);
        exp_t x;
        x.ack = a; x.chk_rd = chk; x.rdata = rd; x.err = e; x.data = d;
        exp_q.push_back(x);
    endtask

    // Monitor: every ack is matched against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (ack_o !== 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=%b required=none", ack_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_ack", 32'(ack_o), 32'(e.ack));
                check("sb_err", 32'(err_o), 32'(e.err));
                check("sb_data", 32'(data_o), 32'(e.data));
                if (e.chk_rd) check("sb_rdata", 32'(rdata_o), 32'(e.rdata));
            end
        end
    end

    task automatic drive(input int k, input logic w, input logic [1:0] a, input logic [7:0] d);
        if (k == 0) begin we0 = w; addr0 = a; wd0 = d; req0 = 1'b1; end
        else        begin we1 = w; addr1 = a; wd1 = d; req1 = 1'b1; end
    endtask

    task automatic drop(input int k);
        if (k == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic wait_ack(input int k);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack_o[k]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_req%0d actual=%b required=ack", k, ack_o);
        end
    endtask

    task automatic single(input int k, input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        drive(k, w, a, d);
        wait_ack(k);
        @(negedge clk);
        drop(k);
        @(negedge clk);
    endtask

    initial begin
        bit bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_ack", 32'(ack_o), 0);
        check("rst_rdata", 32'(rdata_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_data", 32'(data_o), 0);
        reset_i = 1'b1;

        // Single write with latency checks
        @(negedge clk);
        push(2'b01, 1'b0, 8'h00, 1'b0, 24'h0000A5);
        drive(0, 1'b1, 2'd0, 8'hA5);
        @(posedge clk); #1;
        check("t1_gnt", 32'(gnt_o), 32'h1);
        check("t1_busy", 32'(busy_o), 1);
        @(posedge clk); #1;
        check("t1_no_ack_early", 32'(ack_o), 0);
        @(posedge clk); #1;
        check("t1_ack_latency", 32'(ack_o), 32'h1);
        @(negedge clk);
        drop(0);
        @(posedge clk); #1;
        check("t1_gnt_release", 32'(gnt_o), 0);
        check("t1_idle", 32'(busy_o), 0);
        @(negedge clk);

        // Read-after-write across requesters
        push(2'b10, 1'b0, 8'h00, 1'b0, 24'h003CA5);
        single(1, 1'b1, 2'd1, 8'h3C);
        push(2'b01, 1'b1, 8'h3C, 1'b0, 24'h003CA5);
        single(0, 1'b0, 2'd1, 8'h00);

        // Out-of-range write (moves pointer back to 0)
        push(2'b10, 1'b0, 8'h00, 1'b1, 24'h003CA5);
        single(1, 1'b1, 2'd3, 8'h77);

        // Round robin with both requesting: 0,1,0,1
        push(2'b01, 1'b0, 8'h00, 1'b0, 24'h003C11);
        push(2'b10, 1'b0, 8'h00, 1'b0, 24'h223C11);
        push(2'b01, 1'b0, 8'h00, 1'b0, 24'h223C33);
        push(2'b10, 1'b0, 8'h00, 1'b0, 24'h443C33);
        @(negedge clk);
        fork
            begin
                for (int r = 0; r < 2; r++) begin
                    drive(0, 1'b1, 2'd0, (r == 0) ? 8'h11 : 8'h33);
                    wait_ack(0);
                    @(negedge clk);
                    drop(0);
                    @(negedge clk);
                end
            end
            begin
                for (int r = 0; r < 2; r++) begin
                    drive(1, 1'b1, 2'd2, (r == 0) ? 8'h22 : 8'h44);
                    wait_ack(1);
                    @(negedge clk);
                    drop(1);
                    @(negedge clk);
                end
            end
        join
        @(negedge clk);

        // Out-of-range read
        push(2'b01, 1'b1, 8'h00, 1'b1, 24'h443C33);
        single(0, 1'b0, 2'd3, 8'h00);

        // Timeout: requester 1 holds its request after ack
        push(2'b10, 1'b0, 8'h00, 1'b0, 24'h5A3C33);
        push(2'b01, 1'b1, 8'h33, 1'b0, 24'h5A3C33);
        @(negedge clk);
        drive(1, 1'b1, 2'd2, 8'h5A);
        drive(0, 1'b0, 2'd0, 8'h00);
        wait_ack(1);
        bad = 1'b0;
        for (int i = 1; i <= 254; i++) begin
            @(posedge clk); #1;
            if (err_o !== 1'b0 || gnt_o !== 2'b10) bad = 1'b1;
        end
        check("tmo_hold_window", 32'(bad), 0);
        @(posedge clk); #1;
        check("tmo_err", 32'(err_o), 1);
        check("tmo_gnt_drop", 32'(gnt_o), 0);
        @(posedge clk); #1;
        check("tmo_next_gnt", 32'(gnt_o), 32'h1);
        check("tmo_err_pulse", 32'(err_o), 0);
        @(negedge clk);
        drop(1);
        wait_ack(0);
        @(negedge clk);
        drop(0);
        repeat (2) @(negedge clk);

        // Async reset during GRANT of a write
        drive(0, 1'b1, 2'd0, 8'hFF);
        @(posedge clk); #1;
        check("rst_mid_gnt_pre", 32'(gnt_o), 32'h1);
        #2 reset_i = 1'b0;
        #1;
        check("rst_mid_gnt", 32'(gnt_o), 0);
        check("rst_mid_busy", 32'(busy_o), 0);
        check("rst_mid_data", 32'(data_o), 0);
        check("rst_mid_rdata", 32'(rdata_o), 0);
        @(negedge clk);
        drop(0);
        @(negedge clk);
        reset_i = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_after_data", 32'(data_o), 0);
        check("rst_after_gnt", 32'(gnt_o), 0);
        check("sb_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_i2c_regbank_arbiter
`default_nettype wire

// File: doc/i2c_regbank_arbiter.md
Name: i2c_regbank_arbiter

Overview:
Owns the shared configuration register bank that the I2C slave transceiver and on-board local logic (GPMC bridge, test sequencer) both read and write. Arbitrates single-word accesses from NOF_REQUESTERS requesters with round-robin fairness and a req/gnt/ack handshake. Mirrors the whole bank on data_o for CPLD fabric consumers. The I2C slave is wired as requester 0.

Parameters:
NOF_REQUESTERS, 2, number of requester ports (2..4)
NOF_DATA_WORDS, 2, number of 8-bit registers in the bank
NOF_ADDRESS_BITS, 1, address width per requester
TIMEOUT_CYCLES, 255, max cycles a grant may be held after ack before forced release (8-bit counter)

Ports:
clk_i  input  1  system clock; all logic on rising edge
reset_i  input  1  asynchronous, active-low reset
req_i  input  NOF_REQUESTERS  per-requester access request, level
we_i  input  NOF_REQUESTERS  1 = write, 0 = read; sampled at grant
addr_i  input  NOF_REQUESTERS*NOF_ADDRESS_BITS  packed addresses, requester k at slice k
wdata_i  input  NOF_REQUESTERS*8  packed write data
gnt_o  output  NOF_REQUESTERS  one-hot grant, registered
ack_o  output  NOF_REQUESTERS  one-cycle completion pulse to granted requester
rdata_o  output  8  read data, valid in ack cycle
err_o  output  1  one-cycle pulse on timeout or out-of-range access
busy_o  output  1  high whenever state != IDLE
data_o  output  NOF_DATA_WORDS*8  registered bank mirror, word 0 in LSBs

Behaviour:
- Reset (reset_i=0, async): state IDLE, gnt_o=0, ack_o=0, rdata_o=0, err_o=0, busy_o=0, bank and data_o all 0, RR pointer = 0, timeout counter 0. Reset mid-access aborts; no write commits.
- States: IDLE, GRANT, ACCESS, RELEASE.
- IDLE: if any req_i, pick winner = first set bit scanning from pointer upward with wrap; gnt_o<=onehot(winner); capture we/addr/wdata of winner; -> GRANT. No req: stay.
- GRANT (1 cycle): -> ACCESS. Captured operands used; requester changes after capture are ignored.
- ACCESS (1 cycle): write: bank[addr]<=wdata; read: rdata_o<=bank[addr]; ack_o[winner] pulses; pointer<=winner+1 mod NOF_REQUESTERS; -> RELEASE.
- Latency: req seen at edge 0 -> gnt_o high after edge 1 -> ack_o and write/read effect after edge 3; data_o reflects write same edge.
- RELEASE: gnt_o held; when req_i[winner]=0, gnt_o<=0 -> IDLE next cycle. Counter increments each RELEASE cycle; at TIMEOUT_CYCLES: force gnt_o=0, err_o pulse, -> IDLE.
- Out-of-range addr (>= NOF_DATA_WORDS): write dropped, read returns 8'h00, ack still pulses, err_o pulses with ack.
- Simultaneous requests: only one granted; losers hold req and are served in RR order; no requester starves beyond NOF_REQUESTERS-1 accesses.
- req dropped during GRANT: access still completes (ack pulses).
- Read-after-write to same word by another requester returns new value.

Optional Feature:
I2C_ARB_LOCK_EN: adds input lock_i [NOF_REQUESTERS]. If lock_i[winner]=1 in ACCESS, state goes RELEASE->GRANT when winner re-presents req (deasserts then reasserts req, or holds req with new operands after ack), recapturing its operands without rearbitration; pointer not advanced until lock drops; timeout still applies per gap. Without the macro: no lock_i port, every access rearbitrates.

Decomposition:
- Package i2c_arb_pkg: state encoding constants (IDLE/GRANT/ACCESS/RELEASE), WRITE_OP=1'b1/READ_OP=1'b0, timeout counter width.
- Sub-module rr_arbiter: req vector + pointer -> one-hot winner and index, purely combinational; instantiated once.

Test Plan:
- Reset then req_i=2'b01, we=1, addr=0, wdata=8'hA5 -> gnt_o=01 after 1 edge, ack_o=01 after 3 edges, data_o[7:0]=8'hA5, err_o=0.
- Both requesters req simultaneously, pointer 0 -> requester 0 served first, then requester 1; second round both again -> requester 1 first? No: pointer=1 after round 1 serves 1, pointer wraps -> order 0,1,0,1 verified across 4 accesses.
- Requester 1 writes 8'h3C to addr 1, requester 0 then reads addr 1 -> rdata_o=8'h3C in ack cycle.
- Requester 1 holds req 300 cycles after ack (TIMEOUT_CYCLES=255) -> gnt_o drops and err_o pulses exactly 255 RELEASE cycles after ack; requester 0 then granted.
- Out-of-range: NOF_DATA_WORDS=3, NOF_ADDRESS_BITS=2, write addr=3 -> ack pulses, err_o pulses, data_o unchanged; read addr=3 -> rdata_o=8'h00.
- reset_i low during GRANT of write 8'hFF -> outputs zero immediately (async), bank stays 0 after release.
